// File: rtl/fifo_flagged.sv
// Show-ahead synchronous FIFO with occupancy count, watermark flags, synchronous
// flush and sticky overflow/underflow flags for the UART host-side buffers.
module fifo_flagged #(
  parameter int B         = 8,
  parameter int W         = 4,
  parameter int AE_THRESH = 1,
  parameter int AF_THRESH = 2**W - 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         rd,
  input  logic         wr,
  input  logic [B-1:0] w_data,
  input  logic         err_clr,
  output logic [B-1:0] r_data,
  output logic         empty,
  output logic         full,
  output logic         almost_empty,
  output logic         almost_full,
  output logic [W:0]   count,
  output logic         overflow,
  output logic         underflow
);

  localparam logic [W:0] DEPTH = (W+1)'(2**W);
  localparam logic [W:0] AE_LVL = (W+1)'(AE_THRESH);
  localparam logic [W:0] AF_LVL = (W+1)'(AF_THRESH);

  logic [B-1:0] r_mem [2**W];
  logic [W-1:0] r_wrPtr;
  logic [W-1:0] r_rdPtr;
  logic [W:0]   r_count;
  logic         r_empty;
  logic         r_full;
  logic         r_almostEmpty;
  logic         r_almostFull;
  logic         r_overflow;
  logic         r_underflow;

  logic         w_rdEn;
  logic         w_wrEn;
  logic [W:0]   w_countNext;
  logic         w_overflowSet;
  logic         w_underflowSet;

  // A read frees the slot the write lands in, so a full FIFO accepts wr&rd together.
  always_comb begin
    w_rdEn         = rd & ~r_empty & ~clr;
    w_wrEn         = wr & (~r_full | rd) & ~clr;
    w_countNext    = r_count + {{W{1'b0}}, w_wrEn} - {{W{1'b0}}, w_rdEn};
    w_overflowSet  = wr & r_full & ~rd & ~clr;
    w_underflowSet = rd & r_empty & ~clr;
  end

  always_ff @(posedge clk) begin
    if (reset && w_wrEn)
      r_mem[r_wrPtr] <= w_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wrPtr       <= '0;
      r_rdPtr       <= '0;
      r_count       <= '0;
      r_empty       <= 1'b1;
      r_full        <= 1'b0;
      r_almostEmpty <= 1'b1;
      r_almostFull  <= 1'b0;
    end else if (clr) begin
      r_wrPtr       <= '0;
      r_rdPtr       <= '0;
      r_count       <= '0;
      r_empty       <= 1'b1;
      r_full        <= 1'b0;
      r_almostEmpty <= 1'b1;
      r_almostFull  <= 1'b0;
    end else begin
      if (w_wrEn)
        r_wrPtr <= r_wrPtr + W'(1);
      if (w_rdEn)
        r_rdPtr <= r_rdPtr + W'(1);
      r_count       <= w_countNext;
      r_empty       <= (w_countNext == '0);
      r_full        <= (w_countNext == DEPTH);
      r_almostEmpty <= (w_countNext <= AE_LVL);
      r_almostFull  <= (w_countNext >= AF_LVL);
    end
  end

  // Error flags survive a flush; a new error event outranks err_clr.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= w_overflowSet  | (r_overflow  & ~err_clr);
      r_underflow <= w_underflowSet | (r_underflow & ~err_clr);
    end
  end

  assign r_data       = r_mem[r_rdPtr];
  assign empty        = r_empty;
  assign full         = r_full;
  assign almost_empty = r_almostEmpty;
  assign almost_full  = r_almostFull;
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule
